// File: rtl/fact_pkg.sv
// Shared definitions for the memory-mapped factorial accelerator:
// FSM encoding, register offsets and STATUS bit positions.
package fact_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        CALC = 1'b1
    } state_e;

    localparam logic [1:0] OFF_N      = 2'd0;
    localparam logic [1:0] OFF_GO     = 2'd1;
    localparam logic [1:0] OFF_STATUS = 2'd2;
    localparam logic [1:0] OFF_RESULT = 2'd3;

    localparam int unsigned DONE_BIT = 0;
    localparam int unsigned ERR_BIT  = 1;

endpackage

// File: rtl/fact_dp.sv
// Factorial datapath: down-counter, accumulator and WIDTH x N_WIDTH multiplier,
// sequenced by load/clear/step strobes from the controlling FSM.
module fact_dp #(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned N_WIDTH = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load_i,
    input  logic               clear_i,
    input  logic               step_i,
    input  logic [N_WIDTH-1:0] n_i,
    output logic [WIDTH-1:0]   acc_o,
    output logic               cnt_le1_c_o
);

    logic [WIDTH-1:0]   acc_q;
    logic [WIDTH-1:0]   acc_d;
    logic [N_WIDTH-1:0] cnt_q;
    logic [N_WIDTH-1:0] cnt_d;

    // Clear wins over load; only the low WIDTH bits of the product are kept.
    always_comb begin
        acc_d = acc_q;
        cnt_d = cnt_q;
        if (clear_i) begin
            acc_d = '0;
        end else if (load_i) begin
            acc_d = WIDTH'(1);
            cnt_d = n_i;
        end else if (step_i) begin
            acc_d = acc_q * WIDTH'(cnt_q);
            cnt_d = cnt_q - N_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
            cnt_q <= '0;
        end else begin
            acc_q <= acc_d;
            cnt_q <= cnt_d;
        end
    end

    assign acc_o       = acc_q;
    assign cnt_le1_c_o = (cnt_q <= N_WIDTH'(1));

endmodule

// File: rtl/fact_mmio.sv
// Memory-mapped factorial accelerator: N/GO/STATUS/RESULT register file,
// IDLE/CALC control FSM and combinational read mux.
module fact_mmio
    import fact_pkg::*;
#(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned N_WIDTH = 4,
    parameter int unsigned MAX_N   = 12
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             we,
    input  logic [1:0]       a,
    input  logic [WIDTH-1:0] wd,
    output logic [WIDTH-1:0] rd
);

    state_e             state_q;
    logic [N_WIDTH-1:0] n_q;
    logic               go_q;
    logic               done_q;
    logic               err_q;

    logic               wr_n;
    logic               wr_go;
    logic               start;
    logic               n_bad;
    logic               dp_load;
    logic               dp_clear;
    logic               dp_step;
    logic               cnt_le1;
    logic [WIDTH-1:0]   acc;
    logic               unused_wd;

    // Register writes are only honoured while IDLE, so a GO landing on the
    // CALC->IDLE edge is dropped.
    assign wr_n     = we && (a == OFF_N)  && (state_q == IDLE);
    assign wr_go    = we && (a == OFF_GO) && (state_q == IDLE);
    assign start    = wr_go && wd[0];
    assign n_bad    = 32'(n_q) > MAX_N;
    assign dp_load  = start && !n_bad;
    assign dp_clear = start && n_bad;
    assign dp_step  = (state_q == CALC) && !cnt_le1;
    assign unused_wd = ^wd;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            n_q     <= '0;
            go_q    <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            if (wr_n) begin
                n_q <= wd[N_WIDTH-1:0];
            end
            if (wr_go) begin
                go_q <= wd[0];
            end
            case (state_q)
                IDLE: begin
                    if (start) begin
                        done_q  <= n_bad;
                        err_q   <= n_bad;
                        state_q <= n_bad ? IDLE : CALC;
                    end
                end
                CALC: begin
                    if (cnt_le1) begin
                        done_q  <= 1'b1;
                        go_q    <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    fact_dp #(
        .WIDTH   (WIDTH),
        .N_WIDTH (N_WIDTH)
    ) u_dp (
        .clk         (clk),
        .rst_n       (rst_n),
        .load_i      (dp_load),
        .clear_i     (dp_clear),
        .step_i      (dp_step),
        .n_i         (n_q),
        .acc_o       (acc),
        .cnt_le1_c_o (cnt_le1)
    );

    always_comb begin
        rd = '0;
        case (a)
            OFF_N:      rd = WIDTH'(n_q);
            OFF_GO:     rd = WIDTH'(go_q);
            OFF_STATUS: begin
                rd[DONE_BIT] = done_q;
                rd[ERR_BIT]  = err_q;
            end
            OFF_RESULT: rd = acc;
            default:    rd = '0;
        endcase
    end

endmodule

// File: tb/tb_fact_mmio.sv
// Directed bench for fact_mmio: stimulus pushes expected read data into a
// scoreboard queue and a negedge monitor pops and compares each read.
module tb_fact_mmio;

    localparam int unsigned WIDTH = 32;

    logic             clk   = 1'b0;
    logic             rst_n = 1'b0;
    logic             we    = 1'b0;
    logic [1:0]       a     = 2'd0;
    logic [WIDTH-1:0] wd    = '0;
    logic [WIDTH-1:0] rd;

    always #5 clk = ~clk;

    fact_mmio #(
        .WIDTH   (WIDTH),
        .N_WIDTH (4),
        .MAX_N   (12)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (we),
        .a     (a),
        .wd    (wd),
        .rd    (rd)
    );

    typedef struct {
        logic [WIDTH-1:0] exp;
        string            name;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    logic mon_req = 1'b0;
    logic fin_req = 1'b0;
    logic fin_seen = 1'b0;
    int   n_vec = 0;
    int   n_bad = 0;

    // Monitor: one comparison per read strobe, plus a final leftover check.
    always @(negedge clk) begin
        if (mon_req) begin
            if (sb_q.size() == 0) begin
                n_bad++;
                $display("FAIL sb_underflow: read at a=%0d got 0x%08h with no expected entry", a, rd);
            end else begin
                mon_e = sb_q.pop_front();
                n_vec++;
                if (rd !== mon_e.exp) begin
                    n_bad++;
                    $display("FAIL %s: got 0x%08h expected 0x%08h", mon_e.name, rd, mon_e.exp);
                end
            end
        end
        if (fin_req && !fin_seen) begin
            fin_seen <= 1'b1;
            if (sb_q.size() != 0) begin
                n_bad++;
                $display("FAIL sb_leftover: got %0d pending entries expected 0", sb_q.size());
            end
        end
    end

    task automatic rd_chk(input logic [1:0] addr, input logic [WIDTH-1:0] exp, input string name);
        exp_t e;
        e.exp  = exp;
        e.name = name;
        sb_q.push_back(e);
        a       = addr;
        mon_req = 1'b1;
        @(posedge clk);
        #1;
        mon_req = 1'b0;
    endtask

    task automatic wr(input logic [1:0] addr, input logic [WIDTH-1:0] data);
        a  = addr;
        wd = data;
        we = 1'b1;
        @(posedge clk);
        #1;
        we = 1'b0;
    endtask

    // Start a run and check STATUS every edge: busy for 'edges' samples, then done.
    task automatic run_chk(input logic [3:0] n, input int edges,
                           input logic [WIDTH-1:0] res, input string tag);
        wr(2'd0, WIDTH'(n));
        wr(2'd1, WIDTH'(1));
        for (int i = 0; i < edges; i++) rd_chk(2'd2, WIDTH'(0), {tag, "_busy"});
        rd_chk(2'd2, WIDTH'(1), {tag, "_done"});
        rd_chk(2'd3, res, {tag, "_result"});
    endtask

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) rd_chk(2'(i), WIDTH'(0), "rst_read");
        rst_n = 1'b1;
        rd_chk(2'd2, WIDTH'(0), "rst_status");

        run_chk(4'd5, 5, WIDTH'(120), "n5");
        rd_chk(2'd1, WIDTH'(0), "n5_go_cleared");
        rd_chk(2'd0, WIDTH'(5), "n5_nreg");
        run_chk(4'd0, 1, WIDTH'(1), "n0");
        run_chk(4'd1, 1, WIDTH'(1), "n1");
        run_chk(4'd12, 12, 32'h1C8C_FC00, "n12");

        // Out-of-range n: error one edge after GO, then a normal run recovers
        wr(2'd0, WIDTH'(13));
        wr(2'd1, WIDTH'(1));
        rd_chk(2'd2, WIDTH'(3), "n13_status");
        rd_chk(2'd3, WIDTH'(0), "n13_result");
        rd_chk(2'd1, WIDTH'(1), "n13_go");
        run_chk(4'd3, 3, WIDTH'(6), "n3_after_err");

        // Writes to N and GO during CALC are ignored
        wr(2'd0, WIDTH'(6));
        wr(2'd1, WIDTH'(1));
        wr(2'd0, WIDTH'(2));
        wr(2'd1, WIDTH'(1));
        for (int i = 0; i < 4; i++) rd_chk(2'd2, WIDTH'(0), "n6_busy");
        rd_chk(2'd2, WIDTH'(1), "n6_done");
        rd_chk(2'd3, WIDTH'(720), "n6_result");
        rd_chk(2'd0, WIDTH'(6), "n6_nreg");

        // GO on the same edge as CALC->IDLE is dropped
        wr(2'd0, WIDTH'(2));
        wr(2'd1, WIDTH'(1));
        @(posedge clk);
        #1;
        wr(2'd1, WIDTH'(1));
        rd_chk(2'd2, WIDTH'(1), "edge_go_status");
        rd_chk(2'd1, WIDTH'(0), "edge_go_goreg");
        rd_chk(2'd3, WIDTH'(2), "edge_go_result");

        // we=0 leaves registers alone; STATUS/RESULT are read-only
        a  = 2'd0;
        wd = $urandom;
        @(posedge clk);
        #1;
        a  = 2'd1;
        wd = $urandom | 32'd1;
        @(posedge clk);
        #1;
        rd_chk(2'd0, WIDTH'(2), "we0_nreg");
        rd_chk(2'd1, WIDTH'(0), "we0_goreg");
        wr(2'd2, 32'hFFFF_FFFF);
        wr(2'd3, 32'hDEAD_BEEF);
        rd_chk(2'd2, WIDTH'(1), "ro_status");
        rd_chk(2'd3, WIDTH'(2), "ro_result");

        // Reset in the middle of a calculation
        wr(2'd0, WIDTH'(12));
        wr(2'd1, WIDTH'(1));
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        for (int i = 0; i < 4; i++) rd_chk(2'(i), WIDTH'(0), "midrst_read");
        rst_n = 1'b1;
        rd_chk(2'd2, WIDTH'(0), "midrst_status");
        rd_chk(2'd3, WIDTH'(0), "midrst_result");
        run_chk(4'd4, 4, WIDTH'(24), "n4_after_rst");

        fin_req = 1'b1;
        repeat (2) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
